// File: rtl/hazard_pkg.sv
// Shared types and next-state rules for the hazard alarm controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    SAFE  = 2'b00,
    WARN  = 2'b01,
    ALARM = 2'b10,
    ACKED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    RED    = 2'b11
  } level_t;

  // Highest classification wins; all-zero means the classifier has faulted.
  function automatic level_t encode_level(input logic red, input logic yellow, input logic green);
    if (red)         return RED;
    else if (yellow) return YELLOW;
    else if (green)  return GREEN;
    else             return NONE;
  endfunction

  // Acknowledge beats any same-cycle level change; ALARM is latched otherwise.
  // NONE is treated as WARN so a faulted classifier never reads as safe.
  function automatic state_t next_state(input state_t cur, input logic valid,
                                        input level_t lvl, input logic ack);
    state_t nxt;
    nxt = cur;
    if (cur == ALARM) begin
      if (ack) nxt = ACKED;
    end else if (valid) begin
      case (lvl)
        RED:     nxt = (cur == ACKED) ? ACKED : ALARM;
        GREEN:   nxt = SAFE;
        default: nxt = WARN;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hazard_alarm_ctrl_qualifier.sv
// Input synchroniser and run-length qualifier for the classifier lines.
module hazard_qualifier
  import hazard_pkg::*;
#(
  parameter int QUAL_CYCLES = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   red,
  input  logic   yellow,
  input  logic   green,
  output level_t qual_level,
  output logic   qual_valid
);

  localparam int CW = $clog2(QUAL_CYCLES + 1);
  localparam logic [CW-1:0] QMAX = CW'(QUAL_CYCLES);

  logic          sync_red, sync_yellow, sync_green;
  level_t        enc_level, cand, cand_nxt;
  logic [CW-1:0] count, count_nxt;

  // Single register stage absorbs propagation glitches from the gate-level classifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_red    <= 1'b0;
      sync_yellow <= 1'b0;
      sync_green  <= 1'b0;
    end else begin
      sync_red    <= red;
      sync_yellow <= yellow;
      sync_green  <= green;
    end
  end

  assign enc_level = encode_level(sync_red, sync_yellow, sync_green);

  // A change of level restarts the run; an unchanged level counts up and saturates.
  always_comb begin
    cand_nxt  = cand;
    count_nxt = count;
    if (enc_level != cand) begin
      cand_nxt  = enc_level;
      count_nxt = CW'(1);
    end else if (count != QMAX) begin
      count_nxt = count + CW'(1);
    end
  end

  // Qualified level only moves once a candidate has held for the full run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand       <= NONE;
      count      <= '0;
      qual_level <= NONE;
      qual_valid <= 1'b0;
    end else begin
      cand  <= cand_nxt;
      count <= count_nxt;
      if (count_nxt == QMAX) begin
        qual_level <= cand_nxt;
        qual_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_alarm_ctrl.sv
// Latching hazard alarm FSM with LED/buzzer drive and red blink.
//
//   state | meaning
//   SAFE  | qualified green; green LED once a level has been qualified
//   WARN  | qualified yellow or classifier fault (no line asserted)
//   ALARM | red latched; red LED blinks, buzzer on until acknowledged
//   ACKED | operator acknowledged; red LED steady, buzzer off
module hazard_alarm_ctrl
  import hazard_pkg::*;
#(
  parameter int QUAL_CYCLES = 8,
  parameter int BLINK_HALF  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Ired,
  input  logic       Iyellow,
  input  logic       Igreen,
  input  logic       Iack,
  output logic       Lred,
  output logic       Lyellow,
  output logic       Lgreen,
  output logic       Obuzzer,
  output logic [1:0] Ostate
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);

  level_t        qual_level;
  logic          qual_valid;
  state_t        state, state_nxt;
  logic [BW-1:0] blink_cnt;

  hazard_qualifier #(.QUAL_CYCLES(QUAL_CYCLES)) u_qual (
    .clk        (clk),
    .rst        (rst),
    .red        (Ired),
    .yellow     (Iyellow),
    .green      (Igreen),
    .qual_level (qual_level),
    .qual_valid (qual_valid)
  );

  assign state_nxt = next_state(state, qual_valid, qual_level, Iack);
  assign Ostate    = state;

  // Outputs are registered from the next state so they change on the same edge as Ostate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SAFE;
      blink_cnt <= '0;
      Lred      <= 1'b0;
      Lyellow   <= 1'b0;
      Lgreen    <= 1'b0;
      Obuzzer   <= 1'b0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= '0;
      Lred      <= 1'b0;
      Lyellow   <= 1'b0;
      Lgreen    <= 1'b0;
      Obuzzer   <= 1'b0;
      case (state_nxt)
        SAFE:  Lgreen  <= qual_valid;
        WARN:  Lyellow <= 1'b1;
        ALARM: begin
          Obuzzer <= 1'b1;
          if (state != ALARM) begin
            Lred <= 1'b1;
          end else if (blink_cnt == BMAX) begin
            Lred <= ~Lred;
          end else begin
            Lred      <= Lred;
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
        ACKED: Lred <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
